// File: rtl/i2s_rx_deserializer.sv
// I2S master receiver: generates SCK/WS and captures MSB-first slot samples into a valid/ready output.
// Sample is presented 1 clk after its last data bit; an unaccepted sample overwritten sets sticky overrun.
module i2s_rx_deserializer #(
  parameter int CLK_DIV    = 2,
  parameter int DATA_WIDTH = 24,
  parameter int SLOT_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  en_i,
  output logic                  sck_o,
  output logic                  ws_o,
  input  logic                  sd_i,
  output logic [DATA_WIDTH-1:0] sample_o,
  output logic                  chan_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic                  overrun_o
);

  localparam int FRAME = 2 * SLOT_WIDTH;
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int P_W   = $clog2(FRAME);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [P_W-1:0]   P_LAST   = P_W'(FRAME - 1);
  localparam logic [P_W-1:0]   SLOT     = P_W'(SLOT_WIDTH);
  localparam logic [P_W-1:0]   WS_START = P_W'(SLOT_WIDTH - 1);
  localparam logic [P_W-1:0]   DW_P     = P_W'(DATA_WIDTH);
  localparam logic [P_W-1:0]   DW_LAST  = P_W'(DATA_WIDTH - 1);

  logic [DIV_W-1:0]    div_cnt;
  logic [P_W-1:0]      p;
  logic [P_W-1:0]      p_next;
  logic [P_W-1:0]      bit_idx;
  logic                tick;
  logic                sck_rise;
  logic                sck_fall;
  logic                cur_slot;
  logic                done;
  logic                done_chan;
  logic [DATA_WIDTH-1:0] shreg;
  logic [DATA_WIDTH:0]   shreg_ext;

  always_comb begin
    tick      = (div_cnt == DIV_LAST);
    sck_rise  = tick && !sck_o;
    sck_fall  = tick && sck_o;
    p_next    = (p == P_LAST) ? '0 : p + 1'b1;
    cur_slot  = (p >= SLOT);
    bit_idx   = cur_slot ? p - SLOT : p;
    shreg_ext = {shreg, sd_i};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || !en_i) begin
      div_cnt   <= '0;
      sck_o     <= 1'b0;
      ws_o      <= 1'b0;
      p         <= P_LAST;
      shreg     <= '0;
      done      <= 1'b0;
      done_chan <= 1'b0;
      valid_o   <= 1'b0;
      chan_o    <= 1'b0;
      sample_o  <= '0;
      if (rst_i) overrun_o <= 1'b0;
    end else begin
      done <= 1'b0;
      if (tick) begin
        div_cnt <= '0;
        sck_o   <= ~sck_o;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end

      // WS switches one SCK ahead of the slot MSB
      if (sck_fall) begin
        p    <= p_next;
        ws_o <= (p_next >= WS_START) && (p_next != P_LAST);
      end

      if (sck_rise) begin
        if (bit_idx < DW_P) shreg <= shreg_ext[DATA_WIDTH-1:0];
        if (bit_idx == DW_LAST) begin
          done      <= 1'b1;
          done_chan <= cur_slot;
        end
      end

      if (done) begin
        sample_o <= shreg;
        chan_o   <= done_chan;
        valid_o  <= 1'b1;
        if (valid_o && !ready_i) overrun_o <= 1'b1;
      end else if (valid_o && ready_i) begin
        valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_i2s_rx_deserializer.sv
// Directed bench for i2s_rx_deserializer with a behavioural I2S mic driving sd_i from SCK/frame position.
module tb_i2s_rx_deserializer;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        en_i;
  logic        sck_o;
  logic        ws_o;
  logic        sd_i = 1'b0;
  logic [23:0] sample_o;
  logic        chan_o;
  logic        valid_o;
  logic        ready_i;
  logic        overrun_o;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  logic [23:0] left_w  = 24'hA5A5A5;
  logic [23:0] right_w = 24'h123456;
  logic        pad_bit = 1'b0;

  i2s_rx_deserializer #(.CLK_DIV(2), .DATA_WIDTH(24), .SLOT_WIDTH(32)) dut (
    .clk_i(clk), .rst_i(rst_i), .en_i(en_i), .sck_o(sck_o), .ws_o(ws_o), .sd_i(sd_i),
    .sample_o(sample_o), .chan_o(chan_o), .valid_o(valid_o), .ready_i(ready_i),
    .overrun_o(overrun_o)
  );

  always #5 clk = ~clk;

  // Mic model: tracks frame position from SCK falling edges and drives the bit for that position
  logic rst_q = 1'b1;
  logic sck_prev = 1'b0;
  int   mp = 63;

  function automatic logic mic_bit(input int pos);
    int b;
    b = pos % 32;
    if (b >= 24) return pad_bit;
    return (pos < 32) ? left_w[23-b] : right_w[23-b];
  endfunction

  always @(posedge clk) rst_q <= rst_i || !en_i;

  always @(negedge clk) begin
    if (rst_q) mp = 63;
    else if (sck_prev && !sck_o) mp = (mp == 63) ? 0 : mp + 1;
    sck_prev = sck_o;
    sd_i = mic_bit(mp);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic goto(input int n);
    while (cyc < n) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    repeat (2) @(negedge clk);
    rst_i = 1'b0;
    cyc = 0;
  endtask

  task automatic no_valid_until(input int n, input string tag);
    logic saw;
    saw = 1'b0;
    while (cyc < n) begin
      @(negedge clk);
      cyc++;
      saw = saw | valid_o;
    end
    check(tag, {31'd0, saw}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic sck_any;
    logic ovr_all;
    rst_i   = 1'b1;
    en_i    = 1'b1;
    ready_i = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_sck",     {31'd0, sck_o},     32'd0);
    check("rst_ws",      {31'd0, ws_o},      32'd0);
    check("rst_valid",   {31'd0, valid_o},   32'd0);
    check("rst_chan",    {31'd0, chan_o},    32'd0);
    check("rst_sample",  {8'd0, sample_o},   32'd0);
    check("rst_overrun", {31'd0, overrun_o}, 32'd0);

    // SCK waveform and stereo capture with ready held high
    rst_i = 1'b0;
    cyc = 0;
    for (int k = 1; k <= 8; k++) begin
      goto(k);
      check($sformatf("sck_clk%0d", k), {31'd0, sck_o}, 32'((k / 2) % 2));
    end
    goto(98);  check("left_not_yet",   {31'd0, valid_o}, 32'd0);
    goto(99);  check("left_valid",     {31'd0, valid_o}, 32'd1);
               check("left_sample",    {8'd0, sample_o}, 32'hA5A5A5);
               check("left_chan",      {31'd0, chan_o},  32'd0);
    goto(100); check("left_one_clk",   {31'd0, valid_o}, 32'd0);
    goto(127); check("ws_before_rise", {31'd0, ws_o},    32'd0);
    goto(128); check("ws_rise",        {31'd0, ws_o},    32'd1);
    goto(227); check("right_valid",    {31'd0, valid_o}, 32'd1);
               check("right_sample",   {8'd0, sample_o}, 32'h123456);
               check("right_chan",     {31'd0, chan_o},  32'd1);
    goto(228); check("right_one_clk",  {31'd0, valid_o}, 32'd0);
    goto(255); check("ws_before_fall", {31'd0, ws_o},    32'd1);
    goto(256); check("ws_fall",        {31'd0, ws_o},    32'd0);

    // Pad bits driven high must not reach the sample
    left_w = 24'h000001; right_w = 24'h000001; pad_bit = 1'b1;
    do_reset();
    goto(99);  check("pad_left_sample",  {8'd0, sample_o}, 32'h000001);
               check("pad_left_chan",    {31'd0, chan_o},  32'd0);
    goto(227); check("pad_right_sample", {8'd0, sample_o}, 32'h000001);
               check("pad_right_chan",   {31'd0, chan_o},  32'd1);
    left_w = 24'hA5A5A5; right_w = 24'h123456; pad_bit = 1'b0;

    // Backpressure through the whole left slot: overwrite sets overrun
    ready_i = 1'b0;
    do_reset();
    goto(99);  check("bp_left_valid",  {31'd0, valid_o},   32'd1);
               check("bp_left_sample", {8'd0, sample_o},   32'hA5A5A5);
    goto(150); check("bp_hold_valid",  {31'd0, valid_o},   32'd1);
               check("bp_hold_sample", {8'd0, sample_o},   32'hA5A5A5);
               check("bp_no_ovr_yet",  {31'd0, overrun_o}, 32'd0);
    goto(227); check("bp_right_sample", {8'd0, sample_o},  32'h123456);
               check("bp_right_chan",  {31'd0, chan_o},    32'd1);
               check("bp_overrun",     {31'd0, overrun_o}, 32'd1);
    ready_i = 1'b1;
    goto(228); check("bp_drain",       {31'd0, valid_o},   32'd0);
               check("bp_ovr_sticky",  {31'd0, overrun_o}, 32'd1);

    // Ready arriving exactly on the done cycle: no overrun
    ready_i = 1'b0;
    do_reset();
    check("ovr_cleared_by_rst", {31'd0, overrun_o}, 32'd0);
    goto(99);  check("bp2_left_valid", {31'd0, valid_o}, 32'd1);
    goto(226);
    ready_i = 1'b1;
    goto(227); check("bp2_right_sample", {8'd0, sample_o},   32'h123456);
               check("bp2_right_valid",  {31'd0, valid_o},   32'd1);
               check("bp2_no_overrun",   {31'd0, overrun_o}, 32'd0);
    goto(228); check("bp2_drain",        {31'd0, valid_o},   32'd0);
               check("bp2_still_no_ovr", {31'd0, overrun_o}, 32'd0);

    // Reset in the middle of the right slot
    do_reset();
    goto(164); check("mid_ws_right", {31'd0, ws_o}, 32'd1);
    rst_i = 1'b1;
    repeat (2) @(negedge clk);
    check("midrst_sck",    {31'd0, sck_o},   32'd0);
    check("midrst_ws",     {31'd0, ws_o},    32'd0);
    check("midrst_valid",  {31'd0, valid_o}, 32'd0);
    check("midrst_sample", {8'd0, sample_o}, 32'd0);
    rst_i = 1'b0;
    cyc = 0;
    no_valid_until(98, "midrst_no_early_valid");
    goto(99);  check("midrst_left_valid",  {31'd0, valid_o}, 32'd1);
               check("midrst_left_sample", {8'd0, sample_o}, 32'hA5A5A5);
               check("midrst_left_chan",   {31'd0, chan_o},  32'd0);

    // Enable gating mid left slot with overrun already set
    ready_i = 1'b0;
    do_reset();
    goto(227); check("gate_ovr_set", {31'd0, overrun_o}, 32'd1);
    ready_i = 1'b1;
    goto(300);
    en_i = 1'b0;
    sck_any = 1'b0;
    ovr_all = 1'b1;
    repeat (10) begin
      @(negedge clk);
      sck_any = sck_any | sck_o;
      ovr_all = ovr_all & overrun_o;
    end
    check("gate_sck_low",   {31'd0, sck_any}, 32'd0);
    check("gate_ovr_held",  {31'd0, ovr_all}, 32'd1);
    check("gate_valid_low", {31'd0, valid_o}, 32'd0);
    en_i = 1'b1;
    cyc = 0;
    no_valid_until(98, "gate_no_partial_word");
    goto(99);  check("gate_left_valid",  {31'd0, valid_o},   32'd1);
               check("gate_left_sample", {8'd0, sample_o},   32'hA5A5A5);
               check("gate_left_chan",   {31'd0, chan_o},    32'd0);
               check("gate_ovr_sticky",  {31'd0, overrun_o}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/i2s_rx_deserializer.md
# i2s_rx_deserializer

I2S master-mode receiver for the tuner's audio front end. It generates the serial bit clock (SCK) and word select (WS) for an I2S microphone. It shifts in the serial data line and presents each completed channel sample as a parallel word with a valid/ready handshake. The FFT/pitch path downstream consumes these words, and this block is the capture end of the I2S link.

## Interface
Parameters:
- CLK_DIV, 2: system clock cycles per SCK half-period, must be ≥1; SCK period = 2·CLK_DIV clk.
- DATA_WIDTH, 24: significant bits captured per slot, MSB first, 1..SLOT_WIDTH.
- SLOT_WIDTH, 32: SCK cycles per channel slot; frame = 2·SLOT_WIDTH SCK cycles.

Ports:
- clk_i  in  1  system clock; all logic is on the rising edge.
- rst_i  in  1  synchronous, active-high reset.
- en_i  in  1  run enable; low forces the idle/reset state except overrun_o.
- sck_o  out  1  I2S bit clock to the mic.
- ws_o  out  1  I2S word select; 0 selects the left slot and 1 the right slot.
- sd_i  in  1  I2S serial data from the mic, already synchronized to clk_i.
- sample_o  out  DATA_WIDTH  captured two's-complement sample, MSB first as received.
- chan_o  out  1  channel of sample_o; 0 = left, 1 = right.
- valid_o  out  1  sample_o/chan_o are valid.
- ready_i  in  1  consumer accepts the sample when valid_o && ready_i.
- overrun_o  out  1  sticky flag: an unaccepted sample was overwritten.

## Operation
- Divider div_cnt runs 0..CLK_DIV-1. On the clk edge where div_cnt == CLK_DIV-1, sck_o toggles and div_cnt wraps to 0.
- Frame position p runs 0..2·SLOT_WIDTH-1. p advances (mod 2·SLOT_WIDTH) on the clk edge where sck_o goes 1→0, which is the SCK falling edge.
- ws_o updates on the same edge as p. It is 1 when SLOT_WIDTH-1 ≤ p_new < 2·SLOT_WIDTH-1, otherwise 0. WS therefore leads each slot's MSB by one SCK cycle, per standard I2S.
- Capture: on the clk edge where sck_o goes 0→1 (SCK rising), slot = p / SLOT_WIDTH and bit = p mod SLOT_WIDTH.
  - If bit < DATA_WIDTH, sd_i is shifted into the LSB of the shift register.
  - Bits at or beyond DATA_WIDTH are ignored; the mic tri-states there.
- Completion: the rising SCK with bit == DATA_WIDTH-1 raises an internal done pulse for 1 clk.
- Output register on done:
  - sample_o ← shift register including the bit just captured.
  - chan_o ← slot.
  - valid_o ← 1.
  - If valid_o was 1 and ready_i was 0 in that cycle, overrun_o ← 1.
- Handshake:
  - valid_o holds, with sample_o and chan_o stable, until a cycle with ready_i = 1. On the next edge valid_o ← 0, unless done occurs in the same cycle.
  - done && valid_o && ready_i: the old sample is accepted, the new sample is loaded, valid_o stays 1, and overrun_o is unchanged.
- overrun_o clears only on rst_i.
- en_i = 0 for a cycle: on the next edge all state returns to reset values except overrun_o. A partially shifted word is discarded.

## Timing
- Reset values (rst_i = 1 at the clk edge):
  - sck_o = 0, ws_o = 0, p = 2·SLOT_WIDTH-1, div_cnt = 0.
  - valid_o = 0, chan_o = 0, sample_o = 0, overrun_o = 0, shift register = 0.
- The first falling SCK after reset moves p to 0. The first captured word is therefore always left (chan_o = 0).
- First SCK rising edge: CLK_DIV clk after reset release. First falling edge: 2·CLK_DIV clk after release.
- Latency: valid_o asserts on the clk edge immediately after the edge that captures the slot's bit DATA_WIDTH-1 (1 clk).
- Throughput: one sample per SLOT_WIDTH·2·CLK_DIV clk.
- Reset mid-slot: the partial word is discarded, valid_o drops on the next edge, and no sample is emitted for that slot.
- Reset wins over en_i, done, and ready_i in the same cycle.

## Test plan
- Reset/idle with CLK_DIV=2, DATA_WIDTH=24, SLOT_WIDTH=32:
  - Hold rst_i for 3 clk. All outputs match the reset values.
  - After release, sck_o rises at clk 2, falls at clk 4, and has period 4 clk.
  - ws_o rises exactly 124 clk after the first falling edge (p=31) and falls 128 clk later.
- Stereo capture: the mic model drives left 0xA5A5A5 and right 0x123456, MSB at p=0 and p=32 respectively, with ready_i = 1.
  - Expect sample_o=0xA5A5A5, chan_o=0 with valid_o high for 1 clk.
  - Then sample_o=0x123456, chan_o=1, 128 clk later.
- Padding ignored: the mic drives 1s on bits 24..31 of each slot while the data bits are 0x000001. Expect sample_o = 0x000001 (no pad bits shifted in).
- Backpressure:
  - ready_i = 0 for the whole left slot and held until the right sample completes. Expect valid_o held with 0xA5A5A5 stable.
  - On right done: sample_o=0x123456, chan_o=1, overrun_o=1 (sticky).
  - Repeat with ready_i = 1 exactly on the done cycle. Expect overrun_o stays 0.
- Reset mid-operation: assert rst_i while p=40 (mid right slot).
  - Expect no right sample and outputs at reset values.
  - The next emitted sample is left and correct.
- Enable gating: drop en_i for 10 clk mid left slot.
  - Expect sck_o=0 throughout and the partial word discarded.
  - After en_i returns, the first valid sample has chan_o=0 with the correct value.
  - A previously set overrun_o remains 1.
